// File: rtl/run_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the run controller: FSM states, run modes and
// the end-of-run cause reported on why.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      WHY_HALT    = 2'd0,
      WHY_STOP    = 2'd1,
      WHY_BUDGET  = 2'd2,
      WHY_TIMEOUT = 2'd3
   } why_t;

   localparam logic [1:0] MODE_FREE = 2'b00;
   localparam logic [1:0] MODE_STEP = 2'b01;
   localparam logic [1:0] MODE_RUNN = 2'b10;

endpackage

// File: rtl/sat_counter.sv
`timescale 1ns/1ps
// Saturating up-counter with synchronous clear; exposes the value it
// would take on the next increment so callers can compare ahead.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic [W-1:0] next,
   output logic         at_max
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign count  = cnt_q;
   assign at_max = &cnt_q;
   assign next   = at_max ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/run_controller.sv
`timescale 1ns/1ps
// Run control between bench and core: gates en in free-run, step and
// run-N modes, counts enabled cycles and records why the run ended.
module run_controller #(
   parameter int CC_WIDTH = 16,
   parameter int MODE_W   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                step,
   input  logic [MODE_W-1:0]   mode,
   input  logic [CC_WIDTH-1:0] run_len,
   input  logic [CC_WIDTH-1:0] timeout_lim,
   input  logic                halt,
   output logic                en,
   output logic [CC_WIDTH-1:0] cc,
   output logic [1:0]          state,
   output logic                done,
   output logic [1:0]          why
);

   import run_ctrl_pkg::*;

   state_t              state_q, state_d;
   logic                en_q, en_d;
   logic                done_q, done_d;
   logic [1:0]          why_q, why_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [CC_WIDTH-1:0] run_len_q, run_len_d;
   logic [CC_WIDTH-1:0] tlim_q, tlim_d;

   logic [CC_WIDTH-1:0] cc_cnt;
   logic [CC_WIDTH-1:0] cc_nxt;
   logic                cc_max;

   logic start_ok;
   logic step_in;
   logic zero_budget;
   logic runn_q;
   logic hit_timeout;
   logic hit_budget;
   logic ending;
   why_t cause;

   assign start_ok    = start &&
                        (state_q == ST_IDLE || state_q == ST_DONE);
   assign step_in     = (mode == MODE_W'(MODE_STEP));
   assign zero_budget = (mode == MODE_W'(MODE_RUNN)) &&
                        (run_len == '0);
   assign runn_q      = (mode_q == MODE_W'(MODE_RUNN));

   // A zero limit still ends the run once cc would pin at all-ones.
   assign hit_timeout = (tlim_q != '0) ? (cc_nxt == tlim_q)
                                       : (cc_max | (&cc_nxt));
   assign hit_budget  = runn_q && (cc_nxt == run_len_q);

   sat_counter #(.W(CC_WIDTH)) u_cc (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_ok),
      .inc    (en_q),
      .count  (cc_cnt),
      .next   (cc_nxt),
      .at_max (cc_max)
   );

   always_comb begin
      ending = 1'b0;
      cause  = WHY_HALT;
      if (en_q) begin
         if (halt) begin
            ending = 1'b1;
            cause  = WHY_HALT;
         end else if (stop) begin
            ending = 1'b1;
            cause  = WHY_STOP;
         end else if (hit_timeout) begin
            ending = 1'b1;
            cause  = WHY_TIMEOUT;
         end else if (state_q == ST_RUN && hit_budget) begin
            ending = 1'b1;
            cause  = WHY_BUDGET;
         end
      end else if (state_q == ST_STEP && stop) begin
         ending = 1'b1;
         cause  = WHY_STOP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (step_in) begin
                  state_d = ST_STEP;
               end else if (zero_budget) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN, ST_STEP: begin
            if (ending) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mode_d    = mode_q;
      run_len_d = run_len_q;
      tlim_d    = tlim_q;
      why_d     = why_q;
      done_d    = (state_d == ST_DONE);
      if (start_ok) begin
         mode_d    = mode;
         run_len_d = run_len;
         tlim_d    = timeout_lim;
         why_d     = zero_budget ? WHY_BUDGET : WHY_HALT;
      end else if (ending) begin
         why_d = cause;
      end
      // One-cycle pulse per step; a step seen while en is high is dropped.
      en_d = (state_d == ST_RUN) ||
             (state_q == ST_STEP && state_d == ST_STEP &&
              !en_q && step);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         why_q     <= '0;
         mode_q    <= '0;
         run_len_q <= '0;
         tlim_q    <= '0;
      end else begin
         en_q      <= en_d;
         done_q    <= done_d;
         why_q     <= why_d;
         mode_q    <= mode_d;
         run_len_q <= run_len_d;
         tlim_q    <= tlim_d;
      end
   end

   assign en    = en_q;
   assign cc    = cc_cnt;
   assign state = state_q;
   assign done  = done_q;
   assign why   = why_q;

endmodule

// File: tb/tb_run_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for run_controller: drivers queue the expected end
// of each run, a monitor checks cc/why/enabled-cycle count on completion.
module tb_run_controller;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, stop, step, halt;
   logic [1:0]   mode;
   logic [W-1:0] run_len, tlim;
   logic         en, done;
   logic [W-1:0] cc;
   logic [1:0]   state, why;

   logic         start4;
   logic         en4, done4;
   logic [3:0]   cc4;
   logic [1:0]   state4, why4;

   typedef struct packed {
      logic [W-1:0] cc;
      logic [1:0]   why;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   en_cnt = 0;

   always #1 clk = ~clk;

   run_controller #(.CC_WIDTH(W), .MODE_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .step        (step),
      .mode        (mode),
      .run_len     (run_len),
      .timeout_lim (tlim),
      .halt        (halt),
      .en          (en),
      .cc          (cc),
      .state       (state),
      .done        (done),
      .why         (why)
   );

   run_controller #(.CC_WIDTH(4), .MODE_W(2)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .start       (start4),
      .stop        (1'b0),
      .step        (1'b0),
      .mode        (2'b00),
      .run_len     (4'd0),
      .timeout_lim (4'd0),
      .halt        (1'b0),
      .en          (en4),
      .cc          (cc4),
      .state       (state4),
      .done        (done4),
      .why         (why4)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Run length is the earliest event; ties resolve halt, stop,
   // watchdog, budget. A zero watchdog means the all-ones cap.
   function automatic exp_t model(int md, int rl, int tl, int h, int s);
      exp_t e;
      int   n;
      int   w;
      int   tle;
      if (md == 2 && rl == 0) begin
         e.cc  = '0;
         e.why = 2'd2;
         return e;
      end
      n = 32'h7fffffff;
      w = 0;
      if (h > 0 && h < n) begin n = h; w = 0; end
      if (s > 0 && s < n) begin n = s; w = 1; end
      tle = (tl != 0) ? tl : (1 << W) - 1;
      if (tle < n) begin n = tle; w = 3; end
      if (md == 2 && rl < n) begin n = rl; w = 2; end
      e.cc  = n[W-1:0];
      e.why = w[1:0];
      return e;
   endfunction

   initial begin : monitor
      logic prev_done;
      logic prev_idle;
      logic acc;
      exp_t e;
      prev_done = 1'b0;
      prev_idle = 1'b1;
      forever begin
         @(posedge clk);
         #0.5;
         if (rst) begin
            prev_done = 1'b0;
            prev_idle = 1'b1;
            en_cnt    = 0;
         end else begin
            acc = start && (prev_done || prev_idle);
            if (acc) en_cnt = 0;
            if (en) en_cnt++;
            if (done && (!prev_done || acc)) begin
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_done: got done=1 cc=%0d, required no completion", cc);
               end else begin
                  e = sb.pop_front();
                  chk("run_cc", 32'(cc), 32'(e.cc));
                  chk("run_why", 32'(why), 32'(e.why));
                  chk("run_en_cycles", en_cnt, 32'(e.cc));
               end
            end
            prev_done = done;
            prev_idle = (state == 2'd0);
         end
      end
   end

   task automatic wait_done(input string name, input int limit);
      int i;
      for (i = 0; i < limit && !done; i++) @(negedge clk);
      if (!done) begin
         checks++;
         fails++;
         $display("FAIL %s: got done=0 after %0d cycles, required done=1", name, limit);
      end
   endtask

   task automatic run_auto(input int md, input int rl, input int tl,
                           input int h, input int s);
      int k;
      bit fin;
      @(negedge clk);
      mode    = md[1:0];
      run_len = rl[W-1:0];
      tlim    = tl[W-1:0];
      halt    = 1'b0;
      stop    = 1'b0;
      start   = 1'b1;
      sb.push_back(model(md, rl, tl, h, s));
      @(negedge clk);
      start = 1'b0;
      k     = 0;
      fin   = 1'b0;
      for (int i = 0; i < 3000 && !fin; i++) begin
         if (done) begin
            fin = 1'b1;
         end else begin
            if (en) k++;
            halt  = en && (k == h);
            stop  = en && (k == s);
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
         end
      end
      halt  = 1'b0;
      stop  = 1'b0;
      start = 1'b0;
      if (!fin) begin
         checks++;
         fails++;
         $display("FAIL run_bound: got done=0 after 3000 cycles, required done=1");
      end
   endtask

   task automatic step_start(input int tl, input exp_t e);
      @(negedge clk);
      mode  = 2'b01;
      tlim  = tl[W-1:0];
      start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin : stim
      int md, rl, tl, h, s;
      rst = 1'b1;
      start = 0; stop = 0; step = 0; halt = 0; start4 = 0;
      mode = 0; run_len = 0; tlim = 0;
      #5 rst = 1'b0;
      @(negedge clk);
      chk("rst_state", 32'(state), 0);
      chk("rst_en", 32'(en), 0);
      chk("rst_cc", 32'(cc), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_why", 32'(why), 0);

      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 40 && !done4; i++) @(negedge clk);
      chk("sat4_done", 32'(done4), 1);
      chk("sat4_cc", 32'(cc4), 15);
      chk("sat4_why", 32'(why4), 3);

      run_auto(0, 0, 0, 10, 0);
      run_auto(2, 7, 0, 0, 0);
      run_auto(2, 0, 0, 0, 0);
      run_auto(0, 0, 200, 0, 0);
      run_auto(0, 0, 0, 6, 6);
      run_auto(3, 0, 0, 0, 4);
      run_auto(2, 5, 5, 0, 0);

      step_start(0, '{cc: 16'd3, why: 2'd1});
      repeat (2) @(negedge clk);
      step = 1; @(negedge clk); step = 0;
      repeat (3) @(negedge clk);
      step = 1; @(negedge clk); step = 0;
      repeat (3) @(negedge clk);
      step = 1; repeat (2) @(negedge clk); step = 0;
      repeat (3) @(negedge clk);
      stop = 1; @(negedge clk); stop = 0;
      wait_done("step_stop_done", 10);

      step_start(0, '{cc: 16'd1, why: 2'd0});
      step = 1; @(negedge clk); step = 0; halt = 1;
      @(negedge clk); halt = 0;
      wait_done("step_halt_done", 10);

      step_start(2, '{cc: 16'd2, why: 2'd3});
      step = 1; @(negedge clk); step = 0;
      repeat (2) @(negedge clk);
      step = 1; @(negedge clk); step = 0;
      wait_done("step_wdog_done", 10);

      @(negedge clk);
      mode = 0; tlim = 0; start = 1;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 50 && cc != 16'd5; i++) @(negedge clk);
      chk("midrun_reach_cc5", 32'(cc), 5);
      #0.3 rst = 1'b1;
      #0.3;
      chk("midrun_rst_en", 32'(en), 0);
      chk("midrun_rst_cc", 32'(cc), 0);
      chk("midrun_rst_state", 32'(state), 0);
      chk("midrun_rst_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      run_auto(0, 0, 0, 8, 0);

      for (int r = 0; r < 30; r++) begin
         case ($urandom_range(0, 2))
            0: md = 0;
            1: md = 2;
            default: md = 3;
         endcase
         rl = $urandom_range(0, 30);
         tl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
         h  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
         s  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
         if (md != 2 && tl == 0 && h == 0 && s == 0) h = 25;
         run_auto(md, rl, tl, h, s);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
